// File: rtl/if_stage.sv
// Fetch stage with PC register, IF/ID pipeline register and saturating
// stall/flush event counters for the 5-stage pipeline.

module if_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  // Holds at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk) begin
    if (rst)                       count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end
endmodule

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             IFIDWrite,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      pc,
  output logic [31:0]      IFID_instr,
  output logic [31:0]      IFID_pc4,
  output logic             IFID_valid,
  output logic [4:0]       IFID_rs,
  output logic [4:0]       IFID_rt,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int NCNT = 2;

  logic [31:0]                  pc_plus4;
  logic [NCNT-1:0]              cnt_inc;
  logic [NCNT-1:0][CNT_W-1:0]   cnt_q;
  logic [1:0]                   unused_tgt_lsb;

  assign pc_plus4       = pc + 32'd4;
  assign imem_addr      = pc;
  assign unused_tgt_lsb = branch_target[1:0];

  // A redirect overrides the stall controls for both PC and IF/ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      IFID_instr <= NOP_INSTR;
      IFID_pc4   <= '0;
      IFID_valid <= 1'b0;
    end else if (branch_taken) begin
      pc         <= {branch_target[31:2], 2'b00};
      IFID_instr <= NOP_INSTR;
      IFID_pc4   <= '0;
      IFID_valid <= 1'b0;
    end else begin
      if (PCWrite) pc <= pc_plus4;
      if (IFIDWrite) begin
        IFID_instr <= imem_data;
        IFID_pc4   <= pc_plus4;
        IFID_valid <= 1'b1;
      end
    end
  end

  assign IFID_rs = IFID_instr[25:21];
  assign IFID_rt = IFID_instr[20:16];

  // Index 0 counts held-PC cycles (only when not redirected), index 1 flushes.
  assign cnt_inc[0] = !branch_taken && !PCWrite;
  assign cnt_inc[1] = branch_taken;

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    if_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[i]),
      .count (cnt_q[i])
    );
  end

  assign stall_count = cnt_q[0];
  assign flush_count = cnt_q[1];
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a 16-bit-counter and a 2-bit-counter instance share
// stimulus; both are compared every cycle against an arithmetic reference.

module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, pcw, ifw, bt;
  logic [31:0] tgt;

  logic [31:0] addr_a, data_a, pc_a, instr_a, pc4_a;
  logic        valid_a;
  logic [4:0]  rs_a, rt_a;
  logic [15:0] stall_a, flush_a;

  logic [31:0] addr_b, data_b, pc_b, instr_b, pc4_b;
  logic        valid_b;
  logic [4:0]  rs_b, rt_b;
  logic [1:0]  stall_b, flush_b;

  int tests = 0;
  int fails = 0;

  // reference state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stall, m_flush;
  int          m_stall2, m_flush2;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  assign data_a = mem_word(addr_a);
  assign data_b = mem_word(addr_b);

  if_stage #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .PCWrite(pcw), .IFIDWrite(ifw),
    .branch_taken(bt), .branch_target(tgt),
    .imem_addr(addr_a), .imem_data(data_a), .pc(pc_a),
    .IFID_instr(instr_a), .IFID_pc4(pc4_a), .IFID_valid(valid_a),
    .IFID_rs(rs_a), .IFID_rt(rt_a),
    .stall_count(stall_a), .flush_count(flush_a)
  );

  if_stage #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .PCWrite(pcw), .IFIDWrite(ifw),
    .branch_taken(bt), .branch_target(tgt),
    .imem_addr(addr_b), .imem_data(data_b), .pc(pc_b),
    .IFID_instr(instr_b), .IFID_pc4(pc4_b), .IFID_valid(valid_b),
    .IFID_rs(rs_b), .IFID_rt(rt_b),
    .stall_count(stall_b), .flush_count(flush_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    check({step, " pc"},        pc_a, m_pc);
    check({step, " imem_addr"}, addr_a, m_pc);
    check({step, " instr"},     instr_a, m_instr);
    check({step, " pc4"},       pc4_a, m_pc4);
    check({step, " valid"},     {31'd0, valid_a}, {31'd0, m_valid});
    check({step, " rs"},        {27'd0, rs_a}, {27'd0, m_instr[25:21]});
    check({step, " rt"},        {27'd0, rt_a}, {27'd0, m_instr[20:16]});
    check({step, " stall"},     {16'd0, stall_a}, m_stall);
    check({step, " flush"},     {16'd0, flush_a}, m_flush);
    check({step, " pc_b"},      pc_b, m_pc);
    check({step, " instr_b"},   instr_b, m_instr);
    check({step, " stall_b"},   {30'd0, stall_b}, m_stall2);
    check({step, " flush_b"},   {30'd0, flush_b}, m_flush2);
  endtask

  // One clock: apply inputs, advance the reference, compare after the edge.
  task automatic cycle(input logic r, input logic p, input logic f,
                       input logic b, input logic [31:0] t, input string step);
    logic [31:0] fetched;
    rst = r; pcw = p; ifw = f; bt = b; tgt = t;
    fetched = mem_word(m_pc);
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
    end else if (b) begin
      m_pc = t & ~32'd3; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_flush < 65535) m_flush++;
      if (m_flush2 < 3) m_flush2++;
    end else begin
      if (f) begin
        m_instr = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      if (p) m_pc = m_pc + 32'd4;
      else begin
        if (m_stall < 65535) m_stall++;
        if (m_stall2 < 3) m_stall2++;
      end
    end
    #1;
    check_all(step);
  endtask

  initial begin
    rst = 1'b1; pcw = 1'b1; ifw = 1'b1; bt = 1'b0; tgt = '0;
    m_pc = 'x; m_instr = 'x; m_pc4 = 'x; m_valid = 1'bx;
    m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;

    // reset, then first fetch
    cycle(1, 1, 1, 0, 0, "rst0");
    cycle(1, 1, 1, 0, 0, "rst1");
    check("rst pc literal", pc_a, 32'h0);
    check("rst valid literal", {31'd0, valid_a}, 32'd0);
    cycle(0, 1, 1, 0, 0, "fetch0");
    check("fetch0 instr literal", instr_a, mem_word(32'h0));
    check("fetch0 pc4 literal", pc4_a, 32'd4);

    // stall two cycles at pc=8
    cycle(0, 1, 1, 0, 0, "to8");
    cycle(0, 0, 0, 0, 0, "stall1");
    cycle(0, 0, 0, 0, 0, "stall2");
    check("stall pc literal", pc_a, 32'd8);
    check("stall cnt literal", {16'd0, stall_a}, 32'd2);
    cycle(0, 1, 1, 0, 0, "release");
    check("release pc literal", pc_a, 32'd12);

    // branch to 0x40
    cycle(0, 1, 1, 1, 32'h40, "br40");
    check("br40 flush literal", {16'd0, flush_a}, 32'd1);
    cycle(0, 1, 1, 0, 0, "after_br40");
    check("br40 fetched literal", instr_a, mem_word(32'h40));

    // branch with stall controls low, misaligned target
    cycle(0, 0, 0, 1, 32'h23, "br23");
    check("br23 pc literal", pc_a, 32'h20);

    // wrap of pc
    cycle(0, 1, 1, 1, 32'hFFFF_FFFC, "brtop");
    cycle(0, 1, 1, 0, 0, "wrap");
    check("wrap pc literal", pc_a, 32'h0);
    check("wrap pc4 literal", pc4_a, 32'h0);

    // PCWrite=1, IFIDWrite=0 drops the word; IFIDWrite=1, PCWrite=0 refetches
    cycle(0, 1, 0, 0, 0, "drop");
    cycle(0, 0, 1, 0, 0, "refetch");

    // saturate narrow counters, then reset mid-stall
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, "sat_stall");
    check("sat stall_b literal", {30'd0, stall_b}, 32'd3);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1, 32'h100 + 32'(i * 8), "sat_flush");
    check("sat flush_b literal", {30'd0, flush_b}, 32'd3);
    cycle(0, 0, 0, 0, 0, "prerst");
    cycle(1, 0, 0, 0, 0, "midrst");
    check("midrst stall literal", {30'd0, stall_b}, 32'd0);

    // random phase
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0),
            $urandom(), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
